// File: rtl/fpu_mul_seq.sv
// Iterative binary32 multiplier, one shift-add step per cycle, 26-cycle latency.
// Ports: clk, reset (async, active-high), start, a, b -> busy, done, result, flags {N,Z,V,U}.
// Define FPU_MUL_RNE_EN for round-to-nearest-even; otherwise the product is truncated.
module fpu_mul_seq #(
    parameter int MANT_W = 24,
    parameter int ITER   = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [3:0]  flags
);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]         ra, rb;
    logic [2*MANT_W-1:0] acc;
    logic [4:0]          cnt;

    // Operand decode from the latched copies
    logic        sa, sb, sign;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [MANT_W-1:0] ma, mb;

    assign sa   = ra[31];
    assign sb   = rb[31];
    assign ea   = ra[30:23];
    assign eb   = rb[30:23];
    assign fa   = ra[22:0];
    assign fb   = rb[22:0];
    assign sign = sa ^ sb;

    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    // Denormals have a zero exponent and are flushed to zero
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    assign ma = a_zero ? '0 : {1'b1, fa};
    assign mb = b_zero ? '0 : {1'b1, fb};

    // Shift-add partial product for the current multiplier bit
    logic [2*MANT_W-1:0] pp;
    assign pp = mb[cnt] ? ({{MANT_W{1'b0}}, ma} << cnt) : '0;

    // Normalize and round
    logic signed [9:0] exp0, exp1, exp2;
    logic [23:0]       sig;
    logic              inc;
    logic [24:0]       rnd;
    logic [22:0]       frac;

    assign exp0 = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;

    always_comb begin
        sig  = acc[46:23];
        exp1 = exp0;
        if (acc[47]) begin
            sig  = acc[47:24];
            exp1 = exp0 + 10'sd1;
        end
    end

`ifdef FPU_MUL_RNE_EN
    logic guard, sticky;
    always_comb begin
        guard  = acc[22];
        sticky = |acc[21:0];
        if (acc[47]) begin
            guard  = acc[23];
            sticky = |acc[22:0];
        end
    end
    assign inc = guard & (sticky | sig[0]);
`else
    logic unused_low;
    assign unused_low = ^acc[22:0];
    assign inc = 1'b0;
`endif

    assign rnd = {1'b0, sig} + {24'd0, inc};

    // A carry out of the significand means it wrapped to 1.000...
    always_comb begin
        frac = rnd[22:0];
        exp2 = exp1;
        if (rnd[24]) begin
            frac = rnd[23:1];
            exp2 = exp1 + 10'sd1;
        end
    end

    logic [31:0] res;
    logic [3:0]  fl;

    always_comb begin
        res = {sign, exp2[7:0], frac};
        fl  = {sign, 3'b000};
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            res = 32'h7FC00000;
            fl  = 4'b0000;
        end else if (a_inf || b_inf) begin
            res = {sign, 8'hFF, 23'd0};
            fl  = {sign, 3'b010};
        end else if (a_zero || b_zero) begin
            res = {sign, 31'd0};
            fl  = {sign, 3'b100};
        end else if (exp2 >= 10'sd255) begin
            res = {sign, 8'hFF, 23'd0};
            fl  = {sign, 3'b010};
        end else if (exp2 <= 10'sd0) begin
            res = {sign, 31'd0};
            fl  = {sign, 3'b101};
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start) state_nxt = MUL;
            MUL:  if (cnt == 5'(ITER - 1)) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= 32'd0;
            flags  <= 4'd0;
            acc    <= '0;
            cnt    <= 5'd0;
            ra     <= 32'd0;
            rb     <= 32'd0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ra   <= a;
                        rb   <= b;
                        busy <= 1'b1;
                        cnt  <= 5'd0;
                        acc  <= '0;
                    end
                end
                MUL: begin
                    acc <= acc + pp;
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    result <= res;
                    flags  <= fl;
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Self-checking bench for fpu_mul_seq.
// Scoreboard queue holds {result, flags} pushed at launch, popped at done.
module tb_fpu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;
    logic [3:0]  flags;

    int checks   = 0;
    int failures = 0;

    logic [35:0] sbq[$];

    fpu_mul_seq dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    always #5 clk = ~clk;

`ifdef FPU_MUL_RNE_EN
    localparam logic [31:0] RND_RES = 32'h40100002;
`else
    localparam logic [31:0] RND_RES = 32'h40100001;
`endif

    task automatic launch(input logic [31:0] x, input logic [31:0] y,
                          input logic [35:0] e);
        a     = x;
        b     = y;
        start = 1'b1;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    function automatic logic [35:0] pop_exp();
        if (sbq.size() == 0) return 'x;
        return sbq.pop_front();
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL reset_result got=%h exp=0", result);
        end
        checks++;
        if (flags !== 4'd0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", flags);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        logic [31:0] ta [12] = '{
            32'h40000000, 32'h3FC00001, 32'h00000000,
            32'hC0000000, 32'h7F000000, 32'h00800000,
            32'h7FC00001, 32'hC0400000, 32'h00000001,
            32'hBFC00000, 32'h7F400000, 32'h40400000};
        logic [31:0] tb [12] = '{
            32'h40400000, 32'h3FC00001, 32'h7F800000,
            32'h7F800000, 32'h7F000000, 32'h3E800000,
            32'h3F800000, 32'h00000000, 32'h3F800000,
            32'h40000000, 32'h40000000, 32'h40400000};
        logic [31:0] tr [12] = '{
            32'h40C00000, RND_RES,      32'h7FC00000,
            32'hFF800000, 32'h7F800000, 32'h00000000,
            32'h7FC00000, 32'h80000000, 32'h00000000,
            32'hC0400000, 32'h7F800000, 32'h41100000};
        logic [3:0] tf [12] = '{
            4'b0000, 4'b0000, 4'b0000,
            4'b1010, 4'b0010, 4'b0101,
            4'b0000, 4'b1100, 4'b0100,
            4'b1000, 4'b0010, 4'b0000};
        logic [35:0] e;
        int lat;
        for (int i = 0; i < 12; i++) begin
            launch(ta[i], tb[i], {tr[i], tf[i]});
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL arith%0d_busy got=%b exp=1", i, busy);
            end
            wait_done(lat);
            e = pop_exp();
            checks++;
            if (result !== e[35:4]) begin
                failures++;
                $display("FAIL arith%0d_result got=%h exp=%h", i, result, e[35:4]);
            end
            checks++;
            if (flags !== e[3:0]) begin
                failures++;
                $display("FAIL arith%0d_flags got=%b exp=%b", i, flags, e[3:0]);
            end
            checks++;
            if (lat !== 26) begin
                failures++;
                $display("FAIL arith%0d_latency got=%0d exp=26", i, lat);
            end
        end
    endtask

    task automatic test_ignored_start();
        logic [35:0] e;
        logic [31:0] r_at_done;
        int ndone;
        int lat;
        ndone     = 0;
        lat       = 0;
        r_at_done = 32'd0;
        launch(32'h40000000, 32'h40400000, {32'h40C00000, 4'b0000});
        for (int i = 1; i <= 60; i++) begin
            a     = 32'h7F000000;
            b     = 32'h7F000000;
            start = (i == 4) || (i == 11);
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat       = i;
                    r_at_done = result;
                end
            end
        end
        e = pop_exp();
        checks++;
        if (ndone !== 1) begin
            failures++;
            $display("FAIL ignored_ndone got=%0d exp=1", ndone);
        end
        checks++;
        if (lat !== 26) begin
            failures++;
            $display("FAIL ignored_latency got=%0d exp=26", lat);
        end
        checks++;
        if (r_at_done !== e[35:4]) begin
            failures++;
            $display("FAIL ignored_result got=%h exp=%h", r_at_done, e[35:4]);
        end
        checks++;
        if (result !== e[35:4]) begin
            failures++;
            $display("FAIL ignored_held got=%h exp=%h", result, e[35:4]);
        end
    endtask

    task automatic test_reset_abort();
        logic [35:0] e;
        int ndone;
        int lat;
        launch(32'h40000000, 32'h40400000, {32'h40C00000, 4'b0000});
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b exp=0", busy);
        end
        checks++;
        if (result !== 32'd0) begin
            failures++;
            $display("FAIL abort_result got=%h exp=0", result);
        end
        checks++;
        if (flags !== 4'd0) begin
            failures++;
            $display("FAIL abort_flags got=%b exp=0000", flags);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sbq.delete();
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL abort_nodone got=%0d exp=0", ndone);
        end
        launch(32'h3FC00000, 32'h40000000, {32'h40400000, 4'b0000});
        wait_done(lat);
        e = pop_exp();
        checks++;
        if (lat !== 26) begin
            failures++;
            $display("FAIL abort_new_latency got=%0d exp=26", lat);
        end
        checks++;
        if (result !== e[35:4]) begin
            failures++;
            $display("FAIL abort_new_result got=%h exp=%h", result, e[35:4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] e;
        int lat;
        launch(32'hBFC00000, 32'h40000000, {32'hC0400000, 4'b1000});
        wait_done(lat);
        e = pop_exp();
        checks++;
        if ({result, flags} !== e) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", {result, flags}, e);
        end
        launch(32'h40400000, 32'h40400000, {32'h41100000, 4'b0000});
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept_busy got=%b exp=1", busy);
        end
        wait_done(lat);
        e = pop_exp();
        checks++;
        if (lat !== 26) begin
            failures++;
            $display("FAIL b2b_latency got=%0d exp=26", lat);
        end
        checks++;
        if ({result, flags} !== e) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", {result, flags}, e);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        test_reset();
        test_arith();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
